// File: rtl/pic_pkg.sv
// pic_pkg: shared encodings, FSM states and helpers for the PIC control stage
package pic_pkg;
  localparam logic [2:0] F_ICW1 = 3'd0;
  localparam logic [2:0] F_ICW2 = 3'd1;
  localparam logic [2:0] F_ICW3 = 3'd2;
  localparam logic [2:0] F_ICW4 = 3'd3;
  localparam logic [2:0] F_OCW1 = 3'd4;
  localparam logic [2:0] F_OCW2 = 3'd5;
  localparam logic [2:0] RS_IMR = 3'b011;
  localparam logic [2:0] RS_IRR = 3'b001;
  localparam logic [2:0] RS_IRR_ALT = 3'b111;
  localparam logic [2:0] RS_ISR = 3'b101;
  localparam logic [2:0] OCW2_NSEOI = 3'b001;
  localparam logic [2:0] OCW2_SEOI = 3'b011;
  localparam int SPURIOUS_IDX_DEF = 7;
  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_e;
  // Index of the lowest set bit (IR0 is highest priority); 0 when v is empty
  function automatic logic [2:0] first_set(input logic [7:0] v);
    first_set = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) first_set = 3'(i);
  endfunction
endpackage

// File: rtl/pic_control_logic_priority.sv
// pic_priority_resolver: fixed-priority winner among unmasked requests, gated by fully nested ISR
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] irr_i,
  input  logic [7:0] imr_i,
  input  logic [7:0] isr_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);
  logic [7:0] cand;
  // Winner must outrank every in-service level to be presented
  always_comb begin
    cand = irr_i & ~imr_i;
    idx_o = first_set(cand);
    valid_o = |cand && (isr_i == '0 || idx_o < first_set(isr_i));
  end
endmodule

// File: rtl/pic_control_logic.sv
// pic_control_logic: IRR/ISR/IMR, priority, INT and INTA vector sequencing (PIC_AEOI_EN enables auto-EOI)
module pic_control_logic
  import pic_pkg::*;
#(
  parameter int NUM_IR = 8,
  parameter int SPURIOUS_IDX = SPURIOUS_IDX_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_STB,
  input  logic [2:0]        FLAG,
  input  logic [7:0]        CMD_DATA,
  input  logic              RD_ACT,
  input  logic [2:0]        READ_SEL,
  input  logic [NUM_IR-1:0] IR,
  input  logic              INTA_N,
  output logic              INT,
  output logic [7:0]        DATA_OUT,
  output logic              DATA_OE
);
  localparam logic [NUM_IR-1:0] ONE = 1;
  logic [NUM_IR-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, ir_prev_q;
  logic [NUM_IR-1:0] ack_mask, eoi_mask, aeoi_mask;
  logic [4:0] t_q;
  logic ltim_q, sngl_q, ic4_q, aeoi_q, init_q, inta_prev_q, spur_q;
  logic icw1, ocw2, fall, rise, ack, win_valid;
  logic [2:0] win_idx, idx_q;
  logic [7:0] rd_data;
  state_e state_q;

  pic_priority_resolver u_prio (
    .irr_i  (irr_q),
    .imr_i  (imr_q),
    .isr_i  (isr_q),
    .valid_o(win_valid),
    .idx_o  (win_idx)
  );

`ifdef PIC_AEOI_EN
  assign aeoi_mask = (state_q == ACK2 && rise && aeoi_q && !spur_q) ? ONE << idx_q : '0;
`else
  logic unused_aeoi;
  assign aeoi_mask = '0;
  assign unused_aeoi = ^{aeoi_q, spur_q};
`endif

  // Request/service next-state: ack clear beats new edge, ack set beats EOI
  always_comb begin
    icw1 = WR_STB && FLAG == F_ICW1;
    ocw2 = WR_STB && FLAG == F_OCW2;
    fall = inta_prev_q && !INTA_N;
    rise = !inta_prev_q && INTA_N;
    ack = state_q == IDLE && fall && !icw1;
    ack_mask = (ack && win_valid) ? ONE << win_idx : '0;
    eoi_mask = (ocw2 && CMD_DATA[7:5] == OCW2_SEOI) ? ONE << CMD_DATA[2:0] :
               (ocw2 && CMD_DATA[7:5] == OCW2_NSEOI && isr_q != '0) ? ONE << first_set(isr_q) : '0;
    irr_d = icw1 ? '0 : (ltim_q ? IR : irr_q | (IR & ~ir_prev_q)) & ~ack_mask;
    isr_d = icw1 ? '0 : (isr_q & ~eoi_mask & ~aeoi_mask) | ack_mask;
    rd_data = READ_SEL == RS_IMR ? imr_q :
              (READ_SEL == RS_IRR || READ_SEL == RS_IRR_ALT) ? irr_q :
              READ_SEL == RS_ISR ? isr_q : 8'h00;
  end

  // Initialization and mask registers written by command words
  always_ff @(posedge CLK) begin
    if (RST) begin
      t_q <= '0;
      ltim_q <= 1'b0;
      sngl_q <= 1'b0;
      ic4_q <= 1'b0;
      aeoi_q <= 1'b0;
      init_q <= 1'b0;
      imr_q <= '0;
    end else if (WR_STB) begin
      case (FLAG)
        F_ICW1: begin
          ltim_q <= CMD_DATA[3];
          sngl_q <= CMD_DATA[1];
          ic4_q <= CMD_DATA[0];
          imr_q <= '0;
          init_q <= 1'b0;
        end
        F_ICW2: begin
          t_q <= CMD_DATA[7:3];
          if (sngl_q && !ic4_q) init_q <= 1'b1;
        end
        F_ICW3: if (!ic4_q) init_q <= 1'b1;
        F_ICW4: begin
          aeoi_q <= CMD_DATA[1];
          init_q <= 1'b1;
        end
        F_OCW1: imr_q <= CMD_DATA;
        default: ;
      endcase
    end
  end

  // INTA sequencer with registered INT and data-bus outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      irr_q <= '0;
      isr_q <= '0;
      ir_prev_q <= '0;
      inta_prev_q <= 1'b1;
      idx_q <= '0;
      spur_q <= 1'b0;
      INT <= 1'b0;
      DATA_OUT <= 8'h00;
      DATA_OE <= 1'b0;
    end else begin
      irr_q <= irr_d;
      isr_q <= isr_d;
      ir_prev_q <= IR;
      inta_prev_q <= INTA_N;
      INT <= init_q && win_valid && state_q == IDLE;
      if (icw1) begin
        state_q <= IDLE;
        DATA_OE <= 1'b0;
      end else begin
        case (state_q)
          IDLE:
            if (fall) begin
              state_q <= ACK1;
              idx_q <= win_valid ? win_idx : 3'(SPURIOUS_IDX);
              spur_q <= !win_valid;
              DATA_OE <= 1'b0;
            end else begin
              DATA_OE <= RD_ACT;
              if (RD_ACT) DATA_OUT <= rd_data;
            end
          ACK1: if (rise) state_q <= WAIT2;
          WAIT2:
            if (fall) begin
              state_q <= ACK2;
              DATA_OUT <= {t_q, idx_q};
              DATA_OE <= 1'b1;
            end
          ACK2:
            if (rise) begin
              state_q <= IDLE;
              DATA_OE <= 1'b0;
            end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
